// File: rtl/usrt_tx_framer.sv
// rtl/usrt_tx_framer.sv - USRT transmit framer/serializer (start, data, optional parity, 1/2 stop)
//
// Takes one DATA_W-bit word per valid/ready handshake and shifts the frame out
// LSB-first on o_Tx, one line bit every CLKS_PER_BIT clocks.
//
// Optional feature macro: USRT_TX_BREAK_EN (adds i_Break and a BREAK state that
// holds the line low for BREAK_BITS bit periods).
//
// Ports:
//   i_Pclk    clock, rising edge
//   i_Rst_n   synchronous active-low reset
//   i_Valid   word on i_Data is available
//   o_Ready   framer can accept a word (IDLE only)
//   i_Data    payload, LSB first on the line
//   i_Parity  00 none, 01 odd, 10 even, 11 none
//   i_Stop2   0: one stop bit, 1: two stop bits
//   o_Tx      serial line, idles high
//   o_Busy    frame or break in progress
//   o_Done    one-cycle pulse in the final cycle of the last stop bit
//   o_Frame   latched frame image {stop2, stop1, parity, data, start}
//   i_Break   line break request (USRT_TX_BREAK_EN builds only)

module usrt_tx_framer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int BREAK_BITS   = 13
) (
    input  logic              i_Pclk,
    input  logic              i_Rst_n,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [DATA_W-1:0] i_Data,
    input  logic [1:0]        i_Parity,
    input  logic              i_Stop2,
    output logic              o_Tx,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [DATA_W+3:0] o_Frame
`ifdef USRT_TX_BREAK_EN
    ,
    input  logic              i_Break
`endif
);

    localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DBW = $clog2(DATA_W);
    localparam int KBW = (BREAK_BITS > 1) ? $clog2(BREAK_BITS) : 1;
    // The bit counter sequences data bits and, when enabled, break periods.
    localparam int BCW = (DBW > KBW) ? DBW : KBW;

    localparam logic [CCW-1:0] CLK_LAST  = CCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
`ifdef USRT_TX_BREAK_EN
    localparam logic [BCW-1:0] BRK_LAST  = BCW'(BREAK_BITS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [CCW-1:0]    clk_cnt_q, clk_cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              has_par_q, has_par_d;
    logic              stop2_q, stop2_d;
    logic [DATA_W+3:0] frame_q, frame_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              bit_end;
    logic              par_en;
    logic              par_bit;

`ifdef USRT_TX_BREAK_EN
    // A pending break request blocks acceptance while idle.
    assign o_Ready = ~busy_q & ~i_Break;
`else
    assign o_Ready = ~busy_q;
`endif
    assign o_Tx    = tx_q;
    assign o_Busy  = busy_q;
    assign o_Done  = done_q;
    assign o_Frame = frame_q;

    assign accept  = i_Valid & o_Ready;
    assign bit_end = (clk_cnt_q == CLK_LAST);
    assign par_en  = (i_Parity == 2'b01) || (i_Parity == 2'b10);
    // Odd: total ones including parity is odd; even: total is even.
    assign par_bit = (i_Parity == 2'b01) ? ~^i_Data : ^i_Data;

    always_ff @(posedge i_Pclk) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            has_par_q <= 1'b0;
            stop2_q   <= 1'b0;
            frame_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            has_par_q <= has_par_d;
            stop2_q   <= stop2_d;
            frame_q   <= frame_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic. tx_d is the line level of the state being entered, so
    // o_Tx changes exactly on bit boundaries straight from a flop.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        has_par_d = has_par_q;
        stop2_d   = stop2_q;
        frame_d   = frame_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
`ifdef USRT_TX_BREAK_EN
                if (i_Break) begin
                    state_d   = S_BREAK;
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end else
`endif
                if (accept) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = i_Data;
                    has_par_d = par_en;
                    stop2_d   = i_Stop2;
                    frame_d   = {1'b1, 1'b1, (par_en ? par_bit : 1'b1), i_Data, 1'b0};
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        if (has_par_q) begin
                            state_d = S_PARITY;
                            tx_d    = frame_q[DATA_W+1];
                        end else begin
                            state_d = S_STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                    tx_d    = 1'b1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    state_d = stop2_q ? S_STOP2 : S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
`ifdef USRT_TX_BREAK_EN
            S_BREAK: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    if (bit_cnt_q == BRK_LAST) begin
                        state_d   = S_IDLE;
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        // Pulse lands in the last clock of whichever stop bit ends the frame.
        done_d = (((state_d == S_STOP1) && !stop2_q) || (state_d == S_STOP2))
                 && (clk_cnt_d == CLK_LAST);
    end

endmodule

// File: tb/tb_usrt_tx_framer.sv
// tb/tb_usrt_tx_framer.sv - randomized self-checking bench for usrt_tx_framer

module tb_usrt_tx_framer;

    logic       clk;
    logic       rst_n;
    logic       valid   [2];
    logic       ready   [2];
    logic [7:0] data    [2];
    logic [1:0] parity  [2];
    logic       stop2   [2];
    logic       tx      [2];
    logic       busy    [2];
    logic       done    [2];
    logic [11:0] frame  [2];
`ifdef USRT_TX_BREAK_EN
    logic       brk     [2];
`endif

    int n_checks;
    int n_fail;

    // Unit 0: one clock per bit; unit 1: four clocks per bit.
    usrt_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(1), .BREAK_BITS(13)) u_dut1 (
        .i_Pclk(clk), .i_Rst_n(rst_n), .i_Valid(valid[0]), .o_Ready(ready[0]),
        .i_Data(data[0]), .i_Parity(parity[0]), .i_Stop2(stop2[0]),
        .o_Tx(tx[0]), .o_Busy(busy[0]), .o_Done(done[0]), .o_Frame(frame[0])
`ifdef USRT_TX_BREAK_EN
        , .i_Break(brk[0])
`endif
    );

    usrt_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .BREAK_BITS(13)) u_dut4 (
        .i_Pclk(clk), .i_Rst_n(rst_n), .i_Valid(valid[1]), .o_Ready(ready[1]),
        .i_Data(data[1]), .i_Parity(parity[1]), .i_Stop2(stop2[1]),
        .o_Tx(tx[1]), .o_Busy(busy[1]), .o_Done(done[1]), .o_Frame(frame[1])
`ifdef USRT_TX_BREAK_EN
        , .i_Break(brk[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        check({tag, "_tx"},    32'(tx[u]),    32'd1);
        check({tag, "_busy"},  32'(busy[u]),  32'd0);
        check({tag, "_ready"}, 32'(ready[u]), 32'd1);
        check({tag, "_done"},  32'(done[u]),  32'd0);
    endtask

    // Sends one word on unit u and checks every clock of the frame against a
    // bit list built from the framing rules. Called and returns at a negedge.
    // keep=1 leaves i_Valid high with a new word for back-to-back operation.
    // abort_idx>=0 pulses reset during that line bit and stops there.
    task automatic run_frame(input int u, input int cpb, input logic [7:0] d,
                             input logic [1:0] p, input logic s2,
                             input bit keep, input int abort_idx);
        logic        exp_bits[$];
        logic        par;
        logic        pen;
        logic [11:0] exp_frame;
        int          wait_n;
        int          last;

        pen = (p == 2'b01) || (p == 2'b10);
        if (p == 2'b01) par = ($countones(d) % 2) == 0;
        else            par = ($countones(d) % 2) == 1;
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pen) exp_bits.push_back(par);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
        exp_frame = {1'b1, 1'b1, (pen ? par : 1'b1), d, 1'b0};
        last = exp_bits.size() - 1;

        wait_n = 0;
        while (ready[u] !== 1'b1 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_accept", 32'(ready[u]), 32'd1);

        valid[u]  = 1'b1;
        data[u]   = d;
        parity[u] = p;
        stop2[u]  = s2;
        @(posedge clk);
        #1;
        // Scramble inputs mid-frame; the framer must ignore them.
        data[u]   = 8'($urandom);
        parity[u] = 2'($urandom);
        stop2[u]  = 1'($urandom);
        if (!keep) valid[u] = 1'b0;

        for (int k = 0; k <= last; k++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                check("tx_bit",  32'(tx[u]),    32'(exp_bits[k]));
                check("done",    32'(done[u]),  32'((k == last) && (c == cpb - 1)));
                check("busy",    32'(busy[u]),  32'd1);
                check("ready",   32'(ready[u]), 32'd0);
                if (k == 0 && c == 0) check("frame", 32'(frame[u]), 32'(exp_frame));
                if (k == abort_idx && c == 0) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check_idle(u, "abort");
                    check("abort_frame", 32'(frame[u]), 32'd0);
                    rst_n = 1'b1;
                    return;
                end
            end
        end
        @(negedge clk);
        check_idle(u, "after_frame");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int u = 0; u < 2; u++) begin
            valid[u]  = 1'b0;
            data[u]   = '0;
            parity[u] = '0;
            stop2[u]  = 1'b0;
`ifdef USRT_TX_BREAK_EN
            brk[u]    = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_idle(u, "reset");
            check("reset_frame", 32'(frame[u]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Known answer: 0x03 odd parity, one stop.
        run_frame(0, 1, 8'h03, 2'b01, 1'b0, 1'b0, -1);
        check("kat_frame_0x03_odd", 32'(frame[0]), 32'hE06);

        // Parity polarity on two data values.
        run_frame(0, 1, 8'h03, 2'b10, 1'b0, 1'b0, -1);
        check("kat_par_0x03_even", 32'(frame[0][9]), 32'd0);
        run_frame(0, 1, 8'h07, 2'b01, 1'b0, 1'b0, -1);
        check("kat_par_0x07_odd", 32'(frame[0][9]), 32'd0);
        run_frame(0, 1, 8'h07, 2'b10, 1'b0, 1'b0, -1);
        check("kat_par_0x07_even", 32'(frame[0][9]), 32'd1);

        // Four clocks per bit, no parity, two stop bits (44 clocks).
        run_frame(1, 4, 8'hA5, 2'b00, 1'b1, 1'b0, -1);

        // Back-to-back with i_Valid held high.
        run_frame(0, 1, 8'h5A, 2'b10, 1'b0, 1'b1, -1);
        run_frame(0, 1, 8'hC3, 2'b01, 1'b1, 1'b0, -1);

        // Reset during data bit 3 (line bit index 4), then a clean frame.
        run_frame(0, 1, 8'hF0, 2'b01, 1'b0, 1'b0, 4);
        run_frame(0, 1, 8'h96, 2'b10, 1'b1, 1'b0, -1);

        // Randomized frames on both units.
        for (int i = 0; i < 24; i++) begin
            run_frame(0, 1, 8'($urandom), 2'($urandom), 1'($urandom),
                      1'($urandom_range(0, 1)), -1);
        end
        valid[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_frame(1, 4, 8'($urandom), 2'($urandom), 1'($urandom), 1'b0, -1);
        end

`ifdef USRT_TX_BREAK_EN
        // Break wins over a pending word, then the word follows.
        @(negedge clk);
        brk[0]    = 1'b1;
        valid[0]  = 1'b1;
        data[0]   = 8'h3C;
        parity[0] = 2'b01;
        stop2[0]  = 1'b0;
        #1;
        check("break_ready_low", 32'(ready[0]), 32'd0);
        @(posedge clk);
        #1;
        brk[0] = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("break_tx",    32'(tx[0]),    32'd0);
            check("break_busy",  32'(busy[0]),  32'd1);
            check("break_ready", 32'(ready[0]), 32'd0);
            check("break_done",  32'(done[0]),  32'd0);
        end
        run_frame(0, 1, 8'h3C, 2'b01, 1'b0, 1'b0, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
